muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the 16-bit core.
- Takes the decoder's mult/div indication plus the two register operands, runs a shift-add multiply or a restoring divide one bit per cycle, and returns the result with its destination register.
- Holds the pipeline stalled via busy while the operation is in flight.
- Sits beside the ALU in the execute stage and writes back through the normal register-write path.

---
 rtl/muldiv_seq.sv | 93 +++++++++
 tb/tb_muldiv_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiply / restoring divide, one bit per cycle; MULDIV_EARLY_EN ends multiplies early
module muldiv_seq #(
  parameter int RV = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mult,
  input  logic          div,
  input  logic          rem_sel,
  input  logic [RV-1:0] a,
  input  logic [RV-1:0] b,
  input  logic [3:0]    rd_in,
  input  logic          kill,
  output logic          busy,
  output logic          done,
  output logic [RV-1:0] result,
  output logic [3:0]    rd_out,
  output logic          div_zero
);
  localparam int CW = $clog2(RV) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  // r0: accumulator/remainder, r1: multiplicand/quotient, r2: multiplier/divisor
  logic [RV-1:0] r0, r1, r2, r0_nxt, r1_nxt, r2_nxt, res_nxt;
  logic [3:0] rd_q;
  logic op_div, sel, accept, dz, last, ge;
  logic [RV:0] rem_sh;
`ifdef MULDIV_EARLY_EN
  assign last = (cnt == CW'(1)) | (!op_div & ((r2 >> 1) == '0));
`else
  assign last = cnt == CW'(1);
`endif
  always_comb begin
    accept = start & (mult | div) & (state != RUN) & !kill;
    dz = div & (b == '0);
    rem_sh = {r0, r1[RV-1]};
    ge = rem_sh >= {1'b0, r2};
    r0_nxt = op_div ? (ge ? rem_sh[RV-1:0] - r2 : rem_sh[RV-1:0]) : r0 + (r2[0] ? r1 : '0);
    r1_nxt = op_div ? {r1[RV-2:0], ge} : r1 << 1;
    r2_nxt = op_div ? r2 : r2 >> 1;
    res_nxt = (op_div & !sel) ? r1_nxt : r0_nxt;
  end
  always_comb begin
    state_nxt = kill ? IDLE : (state == RUN) ? (last ? DONE : RUN) : accept ? (dz ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      rd_q <= '0;
      op_div <= 1'b0;
      sel <= 1'b0;
      result <= '0;
      rd_out <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CW'(RV);
        r0 <= '0;
        r1 <= a;
        r2 <= b;
        rd_q <= rd_in;
        op_div <= div;
        sel <= rem_sel;
        if (dz) begin
          result <= rem_sel ? a : '1;
          rd_out <= rd_in;
          div_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        r0 <= r0_nxt;
        r1 <= r1_nxt;
        r2 <= r2_nxt;
        if (last & !kill) begin
          result <= res_nxt;
          rd_out <= rd_q;
          div_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors, expected results queued at issue and checked by a done monitor
module tb_muldiv_seq;
  localparam int RV = 16;
  logic clk = 0, reset = 1, start = 0, mult = 0, div = 0, rem_sel = 0, kill = 0;
  logic [RV-1:0] a = '0, b = '0;
  logic [3:0] rd_in = '0;
  logic busy, done, div_zero;
  logic [RV-1:0] result;
  logic [3:0] rd_out;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [RV-1:0] res; logic [3:0] rd; logic dz; int at;} exp_t;
  exp_t q[$];

  muldiv_seq #(.RV(RV)) dut (
    .clk(clk), .reset(reset), .start(start), .mult(mult), .div(div), .rem_sel(rem_sel),
    .a(a), .b(b), .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %0h expected no done (cycle %0d)", result, cyc);
      end else begin
        e = q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("rd_out", int'(rd_out), int'(e.rd));
        chk("div_zero", int'(div_zero), int'(e.dz));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  function automatic int mlat(logic [RV-1:0] bb);
`ifdef MULDIV_EARLY_EN
    int h = 0;
    for (int i = 0; i < RV; i++) if (bb[i]) h = i;
    return bb == '0 ? 2 : h + 2;
`else
    return RV + 1;
`endif
  endfunction

  // drives one request in the current cycle; caller sits at a negedge
  task automatic issue(bit m, bit d, bit rs, logic [RV-1:0] aa, logic [RV-1:0] bb, logic [3:0] rd,
                       logic [RV-1:0] er, bit edz, int lat, bit push);
    start = 1; mult = m; div = d; rem_sel = rs; a = aa; b = bb; rd_in = rd;
    if (push) q.push_back('{er, rd, edz, cyc + lat});
    @(negedge clk);
    start = 0; mult = 0; div = 0; rem_sel = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n < 200), 1);
  endtask

  initial begin
    int l, t0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rd_out", int'(rd_out), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    // 7*6 with busy profile
    l = mlat(16'd6);
    issue(1, 0, 0, 16'd7, 16'd6, 4'd9, 16'h002A, 0, l, 1);
    for (int i = 1; i <= RV + 2; i++) begin
      chk($sformatf("busy_c%0d", i), int'(busy), int'(i <= l));
      @(negedge clk);
    end
    drain();
    issue(1, 0, 0, 16'hFFFF, 16'hFFFF, 4'd1, 16'h0001, 0, 17, 1);
    drain();
    issue(0, 1, 0, 16'd100, 16'd7, 4'd2, 16'd14, 0, 17, 1);
    drain();
    issue(0, 1, 1, 16'd100, 16'd7, 4'd3, 16'd2, 0, 17, 1);
    drain();
    issue(0, 1, 0, 16'hFFFF, 16'd1, 4'd4, 16'hFFFF, 0, 17, 1);
    drain();
    issue(1, 1, 1, 16'hFFFF, 16'h0010, 4'd5, 16'h000F, 0, 17, 1);
    drain();
    issue(0, 1, 0, 16'h1234, 16'd0, 4'd6, 16'hFFFF, 1, 1, 1);
    drain();
    issue(0, 1, 1, 16'h1234, 16'd0, 4'd7, 16'h1234, 1, 1, 1);
    drain();
    repeat (2) @(negedge clk);
    chk("dz_hold_result", int'(result), 16'h1234);
    chk("dz_hold_flag", int'(div_zero), 1);
    // start with neither op is ignored
    issue(0, 0, 0, 16'd5, 16'd5, 4'd8, 16'd0, 0, 0, 0);
    chk("nop_busy", int'(busy), 0);
    // kill in cycle 5, restart in cycle 6
    t0 = cyc;
    issue(1, 0, 0, 16'd3, 16'd5, 4'd10, 16'd0, 0, 0, 0);
    while (cyc < t0 + 5) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    chk("kill_busy", int'(busy), 0);
    chk("kill_result", int'(result), 16'h1234);
    chk("kill_rd_out", int'(rd_out), 7);
    issue(1, 0, 0, 16'd3, 16'd5, 4'd11, 16'd15, 0, mlat(16'd5), 1);
    drain();
    // back-to-back: div accepted in the mult's DONE cycle; start during RUN ignored
    issue(1, 0, 0, 16'h1234, 16'h0010, 4'd12, 16'h2340, 0, mlat(16'h0010), 1);
    l = 0;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
    chk("b2b_done_seen", int'(done), 1);
    issue(0, 1, 0, 16'd9, 16'd3, 4'd13, 16'd3, 0, 17, 1);
    repeat (3) @(negedge clk);
    issue(1, 0, 0, 16'd2, 16'd2, 4'd14, 16'd0, 0, 0, 0);
    drain();
    repeat (2) @(negedge clk);
    chk("b2b_hold_result", int'(result), 3);
    chk("b2b_hold_rd", int'(rd_out), 13);
    // reset mid-operation
    issue(1, 0, 0, 16'd9, 16'd9, 4'd15, 16'd0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    repeat (20) @(negedge clk);
    chk("mid_rst_idle", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
